// File: rtl/reg_file_p.sv
// reg_file_p
// ----------
// Multi-ported register file: one write port, two combinational read ports
// and a sequential clear engine that zeroes the array one register per cycle.
//
// Parameters
//   DATA_W     register width in bits
//   ADDR_W     address width; the file holds 2**ADDR_W registers
//   BYPASS     1 forwards same-cycle write data to a matching read port
//   ZERO_REG0  1 hardwires register 0 to zero
//
// Ports
//   CLK            in   clock, all state changes on its rising edge
//   RESET_N        in   asynchronous active-low reset
//   WRITEENABLE    in   write request for the current cycle
//   WRITEREG       in   write address
//   REGWRITE       in   write data
//   READREG1/2     in   read addresses
//   REGOUT1/2      out  combinational read data
//   CLEAR          in   request to zero all registers, one per cycle
//   BUSY           out  high while the clear sequence runs
//   WRITE_DROPPED  out  one-cycle pulse after a write rejected during a clear

module reg_file_p #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              WRITEENABLE,
  input  logic [ADDR_W-1:0] WRITEREG,
  input  logic [DATA_W-1:0] REGWRITE,
  input  logic [ADDR_W-1:0] READREG1,
  input  logic [ADDR_W-1:0] READREG2,
  output logic [DATA_W-1:0] REGOUT1,
  output logic [DATA_W-1:0] REGOUT2,
  input  logic              CLEAR,
  output logic              BUSY,
  output logic              WRITE_DROPPED
);

  localparam int                NUM_REGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    IDLE,
    CLEARING
  } clr_state_t;

  clr_state_t        state;
  clr_state_t        state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic busy;
  logic write_to_zero;
  logic write_en;
  logic dropped_next;

  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // BUSY comes straight from the registered state, so it rises the cycle
  // after CLEAR is accepted and stays up for exactly NUM_REGS cycles.
  assign busy = (state == CLEARING);

  // Writes to a hardwired register 0 vanish silently: no store, no bypass
  // and no dropped-write pulse.
  assign write_to_zero = (ZERO_REG0 != 0) && (WRITEREG == '0);
  assign write_en      = WRITEENABLE && !busy && !write_to_zero;
  assign dropped_next  = WRITEENABLE && busy && !write_to_zero;

  // Clear sequencer state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Clear sequencer next-state logic. CLEAR is only looked at in IDLE, so a
  // repeated request during a running clear neither restarts nor extends it.
  // CNT wraps back to zero on the same edge that leaves CLEARING.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (CLEAR) begin
          state_next = CLEARING;
          cnt_next   = '0;
        end
      end
      CLEARING: begin
        cnt_next = cnt + ADDR_W'(1);
        if (cnt == LAST_ADDR) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Storage. The clear engine and the write port never collide because
  // writes are blocked while busy; a write in the cycle CLEAR is accepted
  // still lands and is later wiped when CNT reaches that address.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (busy) begin
      regs[cnt] <= '0;
    end else if (write_en) begin
      regs[WRITEREG] <= REGWRITE;
    end
  end

  // Dropped-write flag: a registered single-cycle pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      WRITE_DROPPED <= 1'b0;
    end else begin
      WRITE_DROPPED <= dropped_next;
    end
  end

  // Read port 1. write_en is already low while busy or for a hardwired
  // register 0, so forwarding is suppressed in both of those cases. The
  // reset gate keeps a pending write from being forwarded during reset.
  always_comb begin
    rd1 = regs[READREG1];
    if ((BYPASS != 0) && write_en && (READREG1 == WRITEREG)) begin
      rd1 = REGWRITE;
    end
    if ((ZERO_REG0 != 0) && (READREG1 == '0)) begin
      rd1 = '0;
    end
    if (!RESET_N) begin
      rd1 = '0;
    end
  end

  // Read port 2, identical to port 1.
  always_comb begin
    rd2 = regs[READREG2];
    if ((BYPASS != 0) && write_en && (READREG2 == WRITEREG)) begin
      rd2 = REGWRITE;
    end
    if ((ZERO_REG0 != 0) && (READREG2 == '0)) begin
      rd2 = '0;
    end
    if (!RESET_N) begin
      rd2 = '0;
    end
  end

  assign REGOUT1 = rd1;
  assign REGOUT2 = rd2;
  assign BUSY    = busy;

endmodule

// File: doc/reg_file_p.md
REG_FILE_P -- requirements
Module: reg_file_p

Interface
REQ-001 Parameter DATA_W, default 8: register width in bits.
REQ-002 Parameter ADDR_W, default 3: address width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 disables it.
REQ-004 Parameter ZERO_REG0, default 0: 1 hardwires register 0 to zero.
REQ-005 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-006 CLK  input  1  clock; all state changes on its rising edge.
REQ-007 RESET_N  input  1  asynchronous active-low reset.
REQ-008 WRITEENABLE  input  1  write request for the current cycle.
REQ-009 WRITEREG  input  ADDR_W  write address.
REQ-010 REGWRITE  input  DATA_W  write data.
REQ-011 READREG1, READREG2  input  ADDR_W each  read addresses.
REQ-012 REGOUT1, REGOUT2  output  DATA_W each  read data, combinational.
REQ-013 CLEAR  input  1  synchronous request to zero all registers sequentially.
REQ-014 BUSY  output  1  high while the clear sequence runs.
REQ-015 WRITE_DROPPED  output  1  registered one-cycle pulse flagging a rejected write.

Function
REQ-016 Storage SHALL be NUM_REGS registers of DATA_W bits each.
REQ-017 When WRITEENABLE=1 and BUSY=0, register[WRITEREG] SHALL take REGWRITE on the rising edge.
REQ-018 Reads SHALL be combinational: REGOUTn = register[READREGn], with zero added cycles.
REQ-019 With BYPASS=1, WRITEENABLE=1, BUSY=0 and READREGn==WRITEREG, REGOUTn SHALL equal REGWRITE in the same cycle.
REQ-020 With ZERO_REG0=1, writes to address 0 SHALL be discarded without a WRITE_DROPPED pulse, reads of address 0 SHALL return 0, and address 0 SHALL never bypass.
REQ-021 The clear sequencer SHALL have two states, IDLE and CLEARING, plus a counter CNT of ADDR_W bits.
REQ-022 IDLE to CLEARING: CLEAR=1 sampled in IDLE; CNT loads 0; BUSY=1 from the next cycle.
REQ-023 In CLEARING, each rising edge SHALL zero register[CNT] and increment CNT.
REQ-024 CLEARING to IDLE: the edge that zeroes register[NUM_REGS-1]; BUSY is high for exactly NUM_REGS cycles.
REQ-025 CLEAR asserted during CLEARING SHALL be ignored; the sequence neither restarts nor extends.
REQ-026 WRITEENABLE=1 in the same cycle CLEAR is accepted in IDLE SHALL perform the write; the sequence then clears that register in turn.
REQ-027 WRITEENABLE=1 while BUSY=1 SHALL not modify storage, and WRITE_DROPPED SHALL be 1 in the following cycle only.
REQ-028 During CLEARING, reads SHALL return the current array contents: registers already cleared read 0, the rest keep their old values, and there is no bypass.
REQ-029 WRITE_DROPPED SHALL be 0 in every cycle not covered by REQ-027.
REQ-030 CNT SHALL wrap from NUM_REGS-1 to 0 only at the exit transition and SHALL NOT be observable.

Reset
REQ-031 RESET_N=0 SHALL immediately, without waiting for a clock, force every register to 0, the state to IDLE, CNT to 0, BUSY to 0 and WRITE_DROPPED to 0.
REQ-032 Reset asserted mid-clear SHALL abort the sequence; after release the block is IDLE with all registers 0.
REQ-033 While RESET_N=0, writes and CLEAR SHALL be ignored and REGOUT1/REGOUT2 SHALL read 0.

Verification
REQ-034 Write then read: write 0xA5 to reg 3 -> the next cycle READREG1=3 gives 0xA5 and READREG2=4 gives 0x00.
REQ-035 Bypass: BYPASS=1, WRITEENABLE=1, WRITEREG=5, REGWRITE=0x3C, READREG2=5 -> REGOUT2=0x3C in the same cycle; BYPASS=0 -> old value.
REQ-036 Clear sequence: regs 0..7 = 0x11..0x88, pulse CLEAR -> BUSY high 8 cycles; after 3 cycles reg0..2 = 0 and reg3 = 0x44; all 0 at the end.
REQ-037 Write during clear: write 0xFF to reg 7 while BUSY -> reg 7 unchanged, WRITE_DROPPED=1 for one cycle; CLEAR during BUSY does not lengthen BUSY.
REQ-038 Async reset: assert RESET_N=0 between clock edges mid-clear -> BUSY=0 and all REGOUT=0 before the next edge.
REQ-039 ZERO_REG0=1: write 0x55 to reg 0 -> reads 0, no WRITE_DROPPED, no bypass.
